// File: rtl/vedic_64_issue_ctrl.sv
// vedic_64_issue_ctrl
// Streaming wrapper around the free-running 64x64 vedic multiplier. Operand
// pairs are accepted with a valid/ready handshake, sent to the multiplier, and
// followed through its fixed pipeline latency by a valid/tag shift register.
// Each product is then captured, with its tag, into a small output FIFO.
// Admission is credit based: an operand is only accepted while the operations
// in flight plus the stored products leave room in the FIFO. Products are
// therefore never dropped, whatever the output backpressure.
//
// Ports
//   CLK         clock, rising edge
//   RST_N       synchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    operand pair can be accepted (low while in reset)
//   in_a, in_b  64-bit operands
//   in_tag      user tag, returned with the product
//   mul_a/mul_b registered operands to the multiplier
//   mul_result  128-bit product from the multiplier, LATENCY edges after mul_a/mul_b
//   out_valid   FIFO head valid
//   out_ready   consumer takes the head
//   out_result  product at the FIFO head (registered)
//   out_tag     tag at the FIFO head (registered)
module vedic_64_issue_ctrl #(
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_a,
   input  logic [63:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [63:0]      mul_a,
   output logic [63:0]      mul_b,
   input  logic [127:0]     mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

   logic [LATENCY:0]   vld;
   logic [TAG_W-1:0]   tag_sr [LATENCY+1];
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   occ;
   logic [CNT_W-1:0]   occ_nxt;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [127:0]       mem_res [FIFO_DEPTH];
   logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
   logic               accept;
   logic               fifo_wr;
   logic               pop;
   logic               wr_is_head;

   // Credits use the occupancy before any same-cycle pop, so a pop only
   // frees a slot from the next edge on.
   assign in_ready   = RST_N && (({1'b0, inflight} + {1'b0, occ}) < DEPTH_C);
   assign accept     = in_valid && in_ready;
   assign fifo_wr    = vld[LATENCY];
   assign out_valid  = (occ != '0);
   assign pop        = out_valid && out_ready;
   assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
   assign occ_nxt    = occ + CNT_W'(fifo_wr) - CNT_W'(pop);
   // The entry being written becomes the head when nothing older survives
   // this edge; it has to bypass the storage array into the head register.
   assign wr_is_head = fifo_wr && (occ == CNT_W'(pop));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         vld        <= '0;
         inflight   <= '0;
         occ        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         vld      <= {vld[LATENCY-1:0], accept};
         inflight <= inflight + CNT_W'(accept) - CNT_W'(fifo_wr);
         occ      <= occ_nxt;
         rd_ptr   <= rd_ptr_nxt;
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
         end
         if (wr_is_head) begin
            out_result <= mul_result;
            out_tag    <= tag_sr[LATENCY];
         end else if (occ_nxt != '0) begin
            out_result <= mem_res[rd_ptr_nxt];
            out_tag    <= mem_tag[rd_ptr_nxt];
         end
      end
   end

   // Tag pipeline and FIFO storage carry data only; validity lives in vld/occ.
   always_ff @(posedge CLK) begin
      tag_sr[0] <= in_tag;
      for (int k = 1; k <= LATENCY; k++) begin
         tag_sr[k] <= tag_sr[k-1];
      end
      if (RST_N && fifo_wr) begin
         mem_res[wr_ptr] <= mul_result;
         mem_tag[wr_ptr] <= tag_sr[LATENCY];
      end
   end

   // Credit admission must make a write into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
      !(fifo_wr && (occ == FULL_C)));

endmodule

// File: tb/tb_vedic_64_issue_ctrl.sv
module tb_vedic_64_issue_ctrl;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int TW    = 4;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_a, in_b;
   logic [TW-1:0] in_tag;
   logic [63:0]   mul_a, mul_b;
   logic [127:0]  mul_result;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_result;
   logic [TW-1:0] out_tag;

   always #5 CLK = ~CLK;

   vedic_64_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   // Multiplier stand-in: input register then output register.
   logic [63:0] ma_q = '0, mb_q = '0;
   initial mul_result = '0;
   always @(posedge CLK) begin
      ma_q       <= mul_a;
      mb_q       <= mul_b;
      mul_result <= 128'(ma_q) * 128'(mb_q);
   end

   // Reference model: every accepted-but-not-consumed operation, oldest first.
   // An operation accepted at edge E becomes visible at the output from edge
   // E+LAT+1 on; the block has room while fewer than DEPTH are outstanding.
   typedef struct {
      logic [127:0]  prod;
      logic [TW-1:0] tag;
      int            vis;
   } op_t;
   op_t q[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;

   function automatic bit exp_valid();
      return (q.size() > 0) && (q[0].vis <= cyc);
   endfunction

   function automatic bit exp_ready();
      return (RST_N === 1'b1) && (q.size() < DEPTH);
   endfunction

   function automatic int visible_cnt();
      int n = 0;
      foreach (q[i]) if (q[i].vis <= cyc) n++;
      return n;
   endfunction

   task automatic tick();
      bit            acc, pp, rst;
      logic [127:0]  p;
      logic [TW-1:0] t;
      acc = in_valid && exp_ready();
      pp  = exp_valid() && out_ready;
      rst = (RST_N !== 1'b1);
      p   = 128'(in_a) * 128'(in_b);
      t   = in_tag;
      @(posedge CLK);
      cyc++;
      if (rst) q.delete();
      else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back('{prod: p, tag: t, vis: cyc + LAT + 1});
      end
      #1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; in_valid = 1'b1; in_a = 64'd11; in_b = 64'd13; in_tag = 4'h3;
      out_ready = 1'b0;
      repeat (3) tick();
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready got %b exp 0", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      vectors++;
      if (mul_a !== 64'd0 || mul_b !== 64'd0) begin
         miscompares++; $display("FAIL reset mul_ab got %h/%h exp 0/0", mul_a, mul_b);
      end
      vectors++;
      if (out_result !== 128'd0 || out_tag !== 4'h0) begin
         miscompares++; $display("FAIL reset out got %h/%h exp 0/0", out_result, out_tag);
      end
      in_valid = 1'b0;
      RST_N = 1'b1;
      tick();
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_single();
      int seen = 0, at = -1;
      logic [127:0] r = '0;
      logic [TW-1:0] tg = '0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 64'd3; in_b = 64'd5; in_tag = 4'hA;
      tick();
      in_valid = 1'b0; in_a = 64'd99; in_b = 64'd77; in_tag = 4'h1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (out_valid === 1'b1) begin seen++; at = k; r = out_result; tg = out_tag; end
         vectors++;
         if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL single out_valid got %b exp %b @%0d", out_valid, exp_valid(), cyc); end
         vectors++;
         if (in_ready !== exp_ready()) begin miscompares++; $display("FAIL single in_ready got %b exp %b @%0d", in_ready, exp_ready(), cyc); end
      end
      vectors++;
      if (seen != 1 || at != LAT + 1) begin
         miscompares++; $display("FAIL single timing got %0d cycles at %0d exp 1 at %0d", seen, at, LAT + 1);
      end
      vectors++;
      if (r !== 128'hF || tg !== 4'hA) begin
         miscompares++; $display("FAIL single value got %h/%h exp f/a", r, tg);
      end
   endtask

   task automatic test_max();
      bit done = 0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = '1; in_b = '1; in_tag = 4'h5;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         tick();
         if (out_valid === 1'b1) begin
            done = 1;
            vectors++;
            if (out_result !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 || out_tag !== 4'h5) begin
               miscompares++; $display("FAIL max value got %h/%h exp fffffffffffffffe0000000000000001/5", out_result, out_tag);
            end
         end
      end
      vectors++;
      if (!done) begin miscompares++; $display("FAIL max no output got out_valid 0 exp 1"); end
      tick();
   endtask

   task automatic test_backpressure();
      int i = 1, n = 0;
      logic [127:0]  got [6];
      logic [TW-1:0] gtag [6];
      bit acc;
      out_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (i <= 6); in_a = 64'(i); in_b = 64'(i + 1); in_tag = TW'(i);
         acc = in_valid && exp_ready();
         tick();
         if (acc) i++;
         vectors++;
         if (in_ready !== exp_ready()) begin miscompares++; $display("FAIL bp in_ready got %b exp %b @%0d", in_ready, exp_ready(), cyc); end
         vectors++;
         if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL bp out_valid got %b exp %b @%0d", out_valid, exp_valid(), cyc); end
      end
      vectors++;
      if (i != 5 || in_ready !== 1'b0) begin
         miscompares++; $display("FAIL bp stall got next=%0d in_ready=%b exp next=5 in_ready=0", i, in_ready);
      end
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 128'd2 || out_tag !== 4'h1) begin
         miscompares++; $display("FAIL bp head got %b/%h/%h exp 1/2/1", out_valid, out_result, out_tag);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && (i <= 6 || q.size() > 0); c++) begin
         in_valid = (i <= 6); in_a = 64'(i); in_b = 64'(i + 1); in_tag = TW'(i);
         acc = in_valid && exp_ready();
         if (out_valid === 1'b1 && n < 6) begin got[n] = out_result; gtag[n] = out_tag; n++; end
         tick();
         if (acc) i++;
         vectors++;
         if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL bp_drain out_valid got %b exp %b @%0d", out_valid, exp_valid(), cyc); end
      end
      in_valid = 1'b0;
      vectors++;
      if (n != 6) begin miscompares++; $display("FAIL bp_drain count got %0d exp 6", n); end
      for (int j = 0; j < n; j++) begin
         vectors++;
         if (got[j] !== 128'((j + 1) * (j + 2)) || gtag[j] !== TW'(j + 1)) begin
            miscompares++; $display("FAIL bp_order[%0d] got %0d/%0d exp %0d/%0d", j, got[j], gtag[j], (j + 1) * (j + 2), j + 1);
         end
      end
   endtask

   task automatic test_stream();
      int accepted = 0;
      bit acc;
      for (int c = 0; c < 3000 && (accepted < 100 || q.size() > 0); c++) begin
         in_valid  = (accepted < 100) && ($urandom_range(3) != 0);
         in_a      = {$urandom, $urandom};
         in_b      = {$urandom, $urandom};
         in_tag    = TW'($urandom);
         out_ready = $urandom_range(1);
         acc = in_valid && exp_ready();
         tick();
         if (acc) accepted++;
         vectors++;
         if (in_ready !== exp_ready()) begin miscompares++; $display("FAIL stream in_ready got %b exp %b @%0d", in_ready, exp_ready(), cyc); end
         vectors++;
         if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL stream out_valid got %b exp %b @%0d", out_valid, exp_valid(), cyc); end
         if (exp_valid()) begin
            vectors++;
            if (out_result !== q[0].prod || out_tag !== q[0].tag) begin
               miscompares++; $display("FAIL stream head got %h/%h exp %h/%h @%0d", out_result, out_tag, q[0].prod, q[0].tag, cyc);
            end
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (accepted != 100 || q.size() != 0) begin
         miscompares++; $display("FAIL stream completion got %0d accepted %0d left exp 100/0", accepted, q.size());
      end
   endtask

   task automatic test_full_minus_one();
      bit started = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         in_valid = (c < 24);
         in_a = {32'd0, $urandom}; in_b = {32'd0, $urandom}; in_tag = TW'(c);
         // Start consuming exactly when DEPTH-1 products are stored, so the
         // next write lands on a simultaneous pop.
         if (visible_cnt() >= DEPTH - 1) started = 1;
         out_ready = started;
         tick();
         vectors++;
         if (in_ready !== exp_ready()) begin miscompares++; $display("FAIL full1 in_ready got %b exp %b @%0d", in_ready, exp_ready(), cyc); end
         vectors++;
         if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL full1 out_valid got %b exp %b @%0d", out_valid, exp_valid(), cyc); end
         if (exp_valid()) begin
            vectors++;
            if (out_result !== q[0].prod || out_tag !== q[0].tag) begin
               miscompares++; $display("FAIL full1 head got %h/%h exp %h/%h @%0d", out_result, out_tag, q[0].prod, q[0].tag, cyc);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen = 0, at = -1;
      logic [127:0] r = '0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_a = 64'(k + 2); in_b = 64'(k + 3); in_tag = TW'(k + 8);
         tick();
      end
      in_valid = 1'b0;
      tick();
      RST_N = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid in_ready_low got %b exp 0", in_ready); end
      tick();
      RST_N = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL rst_mid release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid stale got out_valid %b exp 0 @%0d", out_valid, cyc); end
      end
      in_valid = 1'b1; in_a = 64'd7; in_b = 64'd9; in_tag = 4'h6;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (out_valid === 1'b1) begin seen++; at = k; r = out_result; end
      end
      vectors++;
      if (seen != 1 || at != LAT + 1 || r !== 128'd63) begin
         miscompares++; $display("FAIL rst_mid new_op got %0d cycles at %0d value %0d exp 1 at %0d value 63", seen, at, r, LAT + 1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_max();
      test_backpressure();
      test_stream();
      test_full_minus_one();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout bench did not complete");
      $fatal(1);
   end
endmodule
